div_iter: RTL and testbench

Iterative integer divider with early termination and RISC-V special-case handling, for the EXU of the RV64 core. It covers DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW. Each operation is one restoring quotient bit per cycle, and the iteration count is trimmed to the dividend's significant bits. It uses valid/ready handshakes on both the start side and the result side, and a flush input for pipeline kills.

---
 rtl/div_iter_if.sv | 27 ++
 rtl/div_iter.sv | 157 +++++++++++++++
 tb/tb_div_iter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// Handshake and operand bundle between the EXU issue logic and the iterative divider.
// The slave modport is the divider side; the master modport is the requester side.
interface div_iter_if #(
  parameter int WIDTH = 64
);
  logic             i_start_valid;
  logic             o_start_ready;
  logic             i_signed;
  logic             i_divw;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_busy;
  logic             o_end_valid;
  logic             i_end_ready;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;

  modport slave (
    input  i_start_valid, i_signed, i_divw, i_dividend, i_divisor, i_end_ready,
    output o_start_ready, o_busy, o_end_valid, o_quotient, o_remainder
  );

  modport master (
    output i_start_valid, i_signed, i_divw, i_dividend, i_divisor, i_end_ready,
    input  o_start_ready, o_busy, o_end_valid, o_quotient, o_remainder
  );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider for RV64 DIV/DIVU/REM/REMU and their word forms.
// One quotient bit per cycle, iterations trimmed to the dividend's significant bits.
module div_iter #(
  parameter int WIDTH = 64
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_flush,
  div_iter_if.slave bus
);

  localparam int HW = WIDTH / 2;
  localparam int KW = $clog2(WIDTH);
  localparam int NW = KW + 1;
  localparam logic [WIDTH-1:0] MIN_FULL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MIN_WORD = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  function automatic logic [WIDTH-1:0] sext_word(input logic [WIDTH-1:0] v);
    return {{HW{v[HW-1]}}, v[HW-1:0]};
  endfunction

  function automatic logic [WIDTH-1:0] ext_op(input logic [WIDTH-1:0] v,
                                              input logic sgn, input logic w);
    if (!w)  return v;
    if (sgn) return sext_word(v);
    return {{HW{1'b0}}, v[HW-1:0]};
  endfunction

  state_t state, state_nxt;
  logic   acc;

  logic [WIDTH-1:0] dvd_r, dvs_r;
  logic             sgn_r, divw_r;
  logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
  logic [KW-1:0]    k;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] q_out, r_out;

  logic signed [WIDTH-1:0] a_ext, b_ext;
  logic             neg_a, neg_b, dz, ovf;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [NW-1:0]    n_c;

  logic [WIDTH:0]   rp;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign acc               = (state == IDLE) && bus.i_start_valid && !i_flush;
  assign bus.o_start_ready = (state == IDLE);
  assign bus.o_busy        = (state != IDLE);
  assign bus.o_end_valid   = (state == DONE);
  assign bus.o_quotient    = q_out;
  assign bus.o_remainder   = r_out;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Special cases take the FIX slot too, so every op spends at least PREP + FIX.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc) state_nxt = PREP;
      PREP: state_nxt = (dz || ovf || (n_c == '0)) ? FIX : CALC;
      CALC: if (k == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.i_end_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  // PREP: operand extension, magnitudes, significant-bit count, special cases
  always_comb begin
    a_ext   = $signed(ext_op(dvd_r, sgn_r, divw_r));
    b_ext   = $signed(ext_op(dvs_r, sgn_r, divw_r));
    neg_a   = sgn_r & a_ext[WIDTH-1];
    neg_b   = sgn_r & b_ext[WIDTH-1];
    mag_a_c = neg_a ? $unsigned(-a_ext) : $unsigned(a_ext);
    mag_b_c = neg_b ? $unsigned(-b_ext) : $unsigned(b_ext);
    n_c     = '0;
    for (int i = 0; i < WIDTH; i++)
      if (mag_a_c[i]) n_c = NW'(i + 1);
    dz  = (b_ext == '0);
    ovf = sgn_r && (a_ext == $signed(divw_r ? MIN_WORD : MIN_FULL)) && (b_ext == '1);
  end

  // CALC: one restoring step; the partial remainder stays below |divisor|
  always_comb begin
    rp   = {rem, mag_a[k]};
    ge   = (rp >= {1'b0, mag_b});
    diff = rp[WIDTH-1:0] - mag_b;
  end

  // FIX: sign correction and word-result sign extension
  always_comb begin
    q_fix = neg_q ? (~quo + 1'b1) : quo;
    r_fix = neg_r ? (~rem + 1'b1) : rem;
    if (divw_r) begin
      q_fix = sext_word(q_fix);
      r_fix = sext_word(r_fix);
    end
  end

  always_ff @(posedge i_clk) begin
    if (acc) begin
      dvd_r  <= bus.i_dividend;
      dvs_r  <= bus.i_divisor;
      sgn_r  <= bus.i_signed;
      divw_r <= bus.i_divw;
    end
    case (state)
      PREP: begin
        mag_a <= mag_a_c;
        mag_b <= mag_b_c;
        k     <= KW'(n_c - 1'b1);
        if (dz) begin
          quo   <= '1;
          rem   <= $unsigned(a_ext);
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (ovf) begin
          quo   <= $unsigned(a_ext);
          rem   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          quo   <= '0;
          rem   <= '0;
          neg_q <= neg_a ^ neg_b;
          neg_r <= neg_a;
        end
      end
      CALC: begin
        rem    <= ge ? diff : rp[WIDTH-1:0];
        quo[k] <= ge;
        k      <= k - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_out <= '0;
      r_out <= '0;
    end else if (state == FIX && !i_flush) begin
      q_out <= q_fix;
      r_out <= r_fix;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: expected results are queued at issue and
// compared with latency when the divider presents its result.
module tb_div_iter;
  localparam int WIDTH = 64;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(WIDTH)) bus ();
  div_iter #(.WIDTH(WIDTH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flush(flush),
    .bus    (bus)
  );

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  function automatic void model(input logic s, input logic w, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] q,
                                output logic [63:0] r, output int lat);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] ma;
    logic        spc;
    int          n;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      spc = 1'b1;
      if (b32 == 32'd0) begin q32 = '1; r32 = a32; end
      else if (s && a32 == 32'h8000_0000 && b32 == '1) begin q32 = a32; r32 = '0; end
      else begin
        spc = 1'b0;
        if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
        else   begin q32 = a32 / b32; r32 = a32 % b32; end
      end
      q  = {{32{q32[31]}}, q32};
      r  = {{32{r32[31]}}, r32};
      ma = {32'd0, (s && a32[31]) ? (~a32 + 32'd1) : a32};
    end else begin
      spc = 1'b1;
      if (b == 64'd0) begin q = '1; r = a; end
      else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = '0; end
      else begin
        spc = 1'b0;
        if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
        else   begin q = a / b; r = a % b; end
      end
      ma = (s && a[63]) ? (~a + 64'd1) : a;
    end
    n = 0;
    for (int i = 0; i < 64; i++) if (ma[i]) n = i + 1;
    lat = spc ? 2 : n + 2;
  endfunction

  task automatic issue(input logic s, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] q, input logic [63:0] r,
                       input int lat, input string nm);
    int g = 0;
    while (!bus.o_start_ready && g < 200) begin @(posedge clk); #1; g++; end
    checks++;
    if (!bus.o_start_ready) begin
      errors++;
      $display("FAIL %s start_ready: got %0b want 1", nm, bus.o_start_ready);
    end
    sb.push_back('{q, r, lat, nm});
    bus.i_signed      = s;
    bus.i_divw        = w;
    bus.i_dividend    = a;
    bus.i_divisor     = b;
    bus.i_start_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_start_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   cnt = 0;
    while (!bus.o_end_valid && cnt < WIDTH + 10) begin @(posedge clk); #1; cnt++; end
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard: result with empty queue");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (cnt !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", e.nm, cnt, e.lat);
    end
    checks++;
    if (bus.o_quotient !== e.q) begin
      errors++;
      $display("FAIL %s quotient: got %h want %h", e.nm, bus.o_quotient, e.q);
    end
    checks++;
    if (bus.o_remainder !== e.r) begin
      errors++;
      $display("FAIL %s remainder: got %h want %h", e.nm, bus.o_remainder, e.r);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.o_quotient !== e.q || bus.o_remainder !== e.r ||
          bus.o_end_valid !== 1'b1 || bus.o_start_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: got q=%h r=%h v=%0b rdy=%0b want q=%h r=%h v=1 rdy=0",
                 e.nm, h, bus.o_quotient, bus.o_remainder, bus.o_end_valid,
                 bus.o_start_ready, e.q, e.r);
      end
    end
    bus.i_end_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_end_ready = 1'b0;
    checks++;
    if (bus.o_start_ready !== 1'b1 || bus.o_end_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_handshake: got rdy=%0b v=%0b want rdy=1 v=0",
               e.nm, bus.o_start_ready, bus.o_end_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_start_ready !== 1'b1 || bus.o_end_valid !== 1'b0 ||
        bus.o_quotient !== 64'd0 || bus.o_remainder !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b rdy=%0b v=%0b q=%h r=%h want 0 1 0 0 0",
               bus.o_busy, bus.o_start_ready, bus.o_end_valid, bus.o_quotient, bus.o_remainder);
    end
  endtask

  task automatic test_basic();
    issue(0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 9, "divu_100_7");
    collect(0);
    issue(1, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 5, "div_m7_2");
    collect(0);
    issue(1, 0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 5, "div_7_m2");
    collect(0);
    issue(1, 0, 64'd0, 64'd5, 64'd0, 64'd0, 2, "div_zero_dvd");
    collect(0);
  endtask

  task automatic test_special();
    issue(1, 0, 64'h1234, 64'd0, '1, 64'h1234, 2, "div_by_zero");
    collect(0);
    issue(0, 0, 64'h1234, 64'd0, '1, 64'h1234, 2, "divu_by_zero");
    collect(0);
    issue(1, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64'd0, 2, "div_ovf");
    collect(0);
    issue(1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 2, "divw_ovf");
    collect(0);
    issue(0, 1, 64'hABCD_0000_FFFF_FFFF, 64'd1, '1, 64'd0, 34, "divuw_sext");
    collect(0);
  endtask

  task automatic test_hold();
    issue(0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 9, "hold_divu");
    collect(5);
  endtask

  task automatic test_flush();
    bus.i_signed = 1'b0; bus.i_divw = 1'b0;
    bus.i_dividend = 64'd100; bus.i_divisor = 64'd7;
    bus.i_start_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.i_start_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_vs_start: got busy=%0b want 0", bus.o_busy);
    end
    bus.i_start_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_start_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: got busy=%0b rdy=%0b want 0 1", bus.o_busy, bus.o_start_ready);
    end
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.o_end_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_result: got end_valid=%0b want 0 at cycle %0d", bus.o_end_valid, c);
      end
    end
    issue(0, 0, 64'd1000, 64'd33, 64'd30, 64'd10, 12, "after_flush");
    collect(0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b, q, r;
    logic        s, w;
    int          lat, sel;
    for (int t = 0; t < 30; t++) begin
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) a = -a;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 64'd0;
      else if (sel == 1) b = '1;
      else if (sel == 2) begin a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
      else begin
        b = {$urandom, $urandom} >> $urandom_range(20, 63);
        if (b == 64'd0) b = 64'd3;
        if ($urandom_range(0, 2) == 0) b = -b;
      end
      model(s, w, a, b, q, r, lat);
      issue(s, w, a, b, q, r, lat, $sformatf("rand%0d", t));
      collect(0);
    end
  endtask

  task automatic test_reset_midop();
    issue(0, 0, 64'hFFFF, 64'd3, 64'h5555, 64'd0, 18, "pre_reset");
    collect(0);
    bus.i_signed = 1'b0; bus.i_divw = 1'b0;
    bus.i_dividend = 64'hFFFF_FFFF; bus.i_divisor = 64'd5;
    bus.i_start_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_end_valid !== 1'b0 ||
        bus.o_quotient !== 64'd0 || bus.o_remainder !== 64'd0) begin
      errors++;
      $display("FAIL reset_midop: got busy=%0b v=%0b q=%h r=%h want 0 0 0 0",
               bus.o_busy, bus.o_end_valid, bus.o_quotient, bus.o_remainder);
    end
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    bus.i_start_valid = 1'b0;
    bus.i_end_ready = 1'b0;
    bus.i_signed = 1'b0;
    bus.i_divw = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_special();
    test_hold();
    test_flush();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
